// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   Issue stage directly in front of the ALU. It holds the 32 x XLEN integer
//   register file, reads the operands of one decoded op per cycle, stalls on
//   RAW/WAW hazards against a pending-write scoreboard, and presents the
//   operands to the ALU from a one-entry output register with valid/ready.
//   Writebacks from downstream update the register file on the clock edge and
//   are bypassed into same-cycle operand reads.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready        decoded-op handshake
//   in_rs1, in_rs2, in_rd      source / destination register indices
//   in_imm, in_use_imm         sign-extended immediate and B-operand select
//   in_op                      ALU function code, passed through to alu_f
//   wb_we, wb_addr, wb_data    writeback port from the downstream stage
//   out_valid / out_ready      ALU-side handshake
//   alu_a, alu_b, alu_f        operands and function code for the ALU
//   out_rd                     destination index travelling with the op
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [OPW-1:0]  in_op,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [OPW-1:0]  alu_f,
  output logic [4:0]      out_rd
);

  logic [XLEN-1:0] rf_q [32];
  logic [31:0]     pending_q, pending_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]  alu_f_q, alu_f_d;
  logic [4:0]      out_rd_q, out_rd_d;

  logic            hit1, hit2, hitd;
  logic            haz1, haz2, hazw;
  logic [XLEN-1:0] rs1_val, rs2_val, opb_val;
  logic            accept;
  logic [31:0]     set_vec, clr_vec;

  // A writeback landing this cycle both bypasses into reads and retires the
  // matching pending bit, so it never causes a stall on that register.
  always_comb begin
    hit1 = wb_we && (wb_addr == in_rs1);
    hit2 = wb_we && (wb_addr == in_rs2);
    hitd = wb_we && (wb_addr == in_rd);
  end

  always_comb begin
    rs1_val = '0;
    if (in_rs1 != 5'd0) begin
      rs1_val = hit1 ? wb_data : rf_q[in_rs1];
    end
    rs2_val = '0;
    if (in_rs2 != 5'd0) begin
      rs2_val = hit2 ? wb_data : rf_q[in_rs2];
    end
    opb_val = in_use_imm ? in_imm : rs2_val;
  end

  always_comb begin
    haz1     = pending_q[in_rs1] && !hit1;
    haz2     = !in_use_imm && pending_q[in_rs2] && !hit2;
    hazw     = (in_rd != 5'd0) && pending_q[in_rd] && !hitd;
    in_ready = (!out_valid_q || out_ready) && !(haz1 || haz2 || hazw);
    accept   = in_valid && in_ready;
  end

  // Scoreboard: a new reservation beats a retiring writeback to the same reg.
  always_comb begin
    clr_vec      = wb_we ? (32'd1 << wb_addr) : 32'd0;
    set_vec      = (accept && (in_rd != 5'd0)) ? (32'd1 << in_rd) : 32'd0;
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  // Output register: load on accept, drop valid when consumed, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_f_d     = alu_f_q;
    out_rd_d    = out_rd_q;
    if (accept) begin
      out_valid_d = 1'b1;
      alu_a_d     = rs1_val;
      alu_b_d     = opb_val;
      alu_f_d     = in_op;
      out_rd_d    = in_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_f_q     <= '0;
      out_rd_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_f_q     <= alu_f_d;
      out_rd_q    <= out_rd_d;
    end
  end

  // Register file; x0 is never written so it reads as zero from storage too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_we && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_f     = alu_f_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//   Directed scenarios with literal expectations followed by a randomized run.
//   A behavioural model (architectural register array, set of outstanding
//   destinations, one-entry output slot) predicts in_ready and the out_* values
//   and is compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [4:0]  in_op;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_f;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.XLEN(32), .OPW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_use_imm(in_use_imm),
    .in_op     (in_op),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .out_rd    (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mrf [32];
  logic        mout [32];     // destination has a writeback outstanding
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_f, m_rd;
  logic [4:0]  wbq [$];       // outstanding destinations, in issue order

  logic [31:0] e_a, e_r2, e_b;
  logic        e_ready;
  logic        m_acc;

  function automatic logic blocked(input logic [4:0] r, input logic o,
                                   input logic we, input logic [4:0] wa);
    return (r != 5'd0) && o && !(we && wa == r);
  endfunction

  always_comb begin
    e_a = 32'd0;
    if (in_rs1 != 5'd0) e_a = (wb_we && wb_addr == in_rs1) ? wb_data : mrf[in_rs1];
    e_r2 = 32'd0;
    if (in_rs2 != 5'd0) e_r2 = (wb_we && wb_addr == in_rs2) ? wb_data : mrf[in_rs2];
    e_b = in_use_imm ? in_imm : e_r2;
    e_ready = (!m_valid || out_ready)
              && !blocked(in_rs1, mout[in_rs1], wb_we, wb_addr)
              && !(!in_use_imm && blocked(in_rs2, mout[in_rs2], wb_we, wb_addr))
              && !blocked(in_rd, mout[in_rd], wb_we, wb_addr);
  end

  assign m_acc = in_valid && e_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mrf[i]  <= 32'd0;
        mout[i] <= 1'b0;
      end
      m_valid <= 1'b0;
      m_a     <= 32'd0;
      m_b     <= 32'd0;
      m_f     <= 5'd0;
      m_rd    <= 5'd0;
      wbq.delete();
    end else begin
      if (m_acc) begin
        m_valid <= 1'b1;
        m_a     <= e_a;
        m_b     <= e_b;
        m_f     <= in_op;
        m_rd    <= in_rd;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      if (wb_we && wb_addr != 5'd0) mrf[wb_addr] <= wb_data;
      if (wb_we) mout[wb_addr] <= 1'b0;
      if (m_acc && in_rd != 5'd0) begin
        mout[in_rd] <= 1'b1;
        wbq.push_back(in_rd);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_f", 32'(alu_f), 32'(m_f));
      chk("out_rd", 32'(out_rd), 32'(m_rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] imm,
                        input logic ui, input logic [4:0] op);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_imm = imm; in_use_imm = ui; in_op = op;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);

    // 1: out of reset, then read never-written registers
    rst_n = 1'b1;
    #3;
    chk("t1_out_valid_rst", 32'(out_valid), 32'd0);
    chk("t1_in_ready_rst", 32'(in_ready), 32'd1);
    chk("t1_alu_a_rst", alu_a, 32'd0);
    @(negedge clk);
    set_in(1'b1, 5'd5, 5'd6, 5'd0, 32'd0, 1'b0, 5'd2);
    @(negedge clk);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    #3;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_alu_a", alu_a, 32'd0);
    chk("t1_alu_b", alu_b, 32'd0);

    // 2: writeback then read through the register file
    @(negedge clk);
    set_wb(1'b1, 5'd5, 32'h12345678);
    @(negedge clk);
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b1, 5'd5, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    @(negedge clk);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    #3;
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_alu_a", alu_a, 32'h12345678);
    chk("t2_alu_b", alu_b, 32'd0);
    chk("t2_alu_f", 32'(alu_f), 32'd0);

    // 3: same-cycle bypass, and x0 ignores writes
    @(negedge clk);
    set_wb(1'b1, 5'd3, 32'hDEADBEEF);
    set_in(1'b1, 5'd3, 5'd0, 5'd0, 32'd0, 1'b0, 5'd1);
    @(negedge clk);
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    #3;
    chk("t3_bypass_a", alu_a, 32'hDEADBEEF);
    @(negedge clk);
    set_wb(1'b1, 5'd0, 32'h11111111);
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    @(negedge clk);
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    #3;
    chk("t3_x0_a", alu_a, 32'd0);
    chk("t3_x0_b", alu_b, 32'd0);

    // 4: RAW stall until the writeback arrives, accepted in that cycle
    @(negedge clk);
    set_in(1'b1, 5'd0, 5'd0, 5'd7, 32'd0, 1'b0, 5'd4);
    @(negedge clk);
    set_in(1'b1, 5'd7, 5'd0, 5'd0, 32'd0, 1'b0, 5'd6);
    #3;
    chk("t4_stall1", 32'(in_ready), 32'd0);
    @(negedge clk);
    #3;
    chk("t4_stall2", 32'(in_ready), 32'd0);
    @(negedge clk);
    set_wb(1'b1, 5'd7, 32'h000000A5);
    #3;
    chk("t4_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    #3;
    chk("t4_alu_a", alu_a, 32'h000000A5);
    chk("t4_out_valid", 32'(out_valid), 32'd1);

    // 5: immediate bypasses a pending rs2; backpressure holds everything
    @(negedge clk);
    set_in(1'b1, 5'd0, 5'd0, 5'd9, 32'd0, 1'b0, 5'd0);
    @(negedge clk);
    set_in(1'b1, 5'd0, 5'd9, 5'd0, 32'hFFFFFFF0, 1'b1, 5'd3);
    #3;
    chk("t5_imm_no_stall", 32'(in_ready), 32'd1);
    @(negedge clk);
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("t5_hold_b", alu_b, 32'hFFFFFFF0);
      chk("t5_hold_f", 32'(alu_f), 32'd3);
      chk("t5_hold_valid", 32'(out_valid), 32'd1);
      chk("t5_hold_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end

    // 6: asynchronous reset mid-handshake with x9 pending
    set_in(1'b0, 5'd9, 5'd5, 5'd9, 32'd0, 1'b0, 5'd0);
    #5;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 5'd9, 5'd5, 5'd9, 32'd0, 1'b0, 5'd7);
    #3;
    chk("t6_no_stall", 32'(in_ready), 32'd1);
    @(negedge clk);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    #3;
    chk("t6_out_valid", 32'(out_valid), 32'd1);
    chk("t6_alu_a", alu_a, 32'd0);
    chk("t6_alu_b_rf_cleared", alu_b, 32'd0);
    chk("t6_out_rd", 32'(out_rd), 32'd9);

    // Randomized phase: downstream honours the one-writeback-per-rd contract
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1500) rst_n = 1'b1;
      set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
        set_wb(1'b1, wbq.pop_front(), $urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        set_wb(1'b1, 5'd0, $urandom);
      end else begin
        set_wb(1'b0, 5'($urandom), $urandom);
      end
      if (cyc == 1499) begin
        #5;
        rst_n = 1'b0;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
